spi_slave_rx: RTL and testbench



---
 rtl/spi_i2c_pkg.sv | 30 +++
 rtl/byte_fifo.sv | 54 +++++
 rtl/spi_slave_rx.sv | 178 +++++++++++++++++
 tb/tb_spi_slave_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_i2c_pkg.sv
// Shared definitions for the SPI-to-I2C bridge: SPI front-end FSM encoding,
// status-byte layout and FIFO sizing defaults.
package spi_i2c_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

    localparam int unsigned STAT_OVR   = 7;
    localparam int unsigned STAT_FULL  = 6;
    localparam int unsigned STAT_EMPTY = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_LOCKOUT = 2'd2
    } spi_state_e;

    // Status byte returned on MISO: {overrun, full, empty, 5'b0}
    function automatic logic [BYTE_W-1:0] status_byte(input logic ovr,
                                                      input logic full,
                                                      input logic empty);
        logic [BYTE_W-1:0] s;
        s             = '0;
        s[STAT_OVR]   = ovr;
        s[STAT_FULL]  = full;
        s[STAT_EMPTY] = empty;
        return s;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted only
// when a pop happens in the same cycle.
module byte_fifo
    import spi_i2c_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned WIDTH = BYTE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign head_data = mem[rd_ptr[AW-1:0]];

    // Storage and pointers; entries clear on reset so the head reads 0 when empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receive front end: synchronises the SPI pins, deserialises
// MOSI bytes into a FWFT FIFO and shifts a status byte out on MISO.
module spi_slave_rx
    import spi_i2c_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              frame_err
);

    localparam int unsigned CNT_W = 3;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [BYTE_W-2:0] rx_q, rx_d;
    logic [BYTE_W-1:0] tx_q, tx_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              miso_oe_q, miso_oe_d;

    logic              push_c;
    logic [BYTE_W-1:0] push_data_c;
    logic              pop_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] status_c;

    // Pin synchronisers. The cs_n chain resets low so that a frame already in
    // progress at reset release is held in LOCKOUT until the pin is seen high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_prev;
    assign sclk_fall = !sclk_s && sclk_prev;
    assign cs_rise   = cs_s && !cs_prev;
    assign cs_fall   = !cs_s && cs_prev;

    assign pop_c       = !fifo_empty && out_ready;
    assign push_data_c = {rx_q, mosi_s};
    assign status_c    = status_byte(overrun_q, fifo_full, fifo_empty);

    // State and shift-register flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_LOCKOUT;
            bit_cnt_q   <= '0;
            tx_cnt_q    <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        miso_oe_d   = miso_oe_q;
        push_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    tx_d      = status_c;
                    overrun_d = 1'b0;
                    bit_cnt_d = '0;
                    tx_cnt_d  = '0;
                    miso_oe_d = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    frame_err_d = (bit_cnt_q != '0);
                    miso_oe_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    if (sclk_rise) begin
                        rx_d      = push_data_c[BYTE_W-2:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        push_c    = (bit_cnt_q == CNT_W'(7));
                    end
                    // Falling edge: next MISO bit, or a fresh status byte after eight
                    if (sclk_fall) begin
                        tx_d     = (tx_cnt_q == CNT_W'(7)) ? status_c : {tx_q[BYTE_W-2:0], 1'b0};
                        tx_cnt_d = tx_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOCKOUT: begin
                miso_oe_d = 1'b0;
                if (cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (push_c && fifo_full && !pop_c) begin
            overrun_d = 1'b1;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (push_data_c),
        .pop       (pop_c),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign spi_miso  = miso_oe_q ? tx_q[BYTE_W-1] : 1'bz;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: bit-banged SPI host, queue-based model of
// the byte stream and status byte, separate monitor comparing every pop.
module tb_spi_slave_rx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;
    localparam int          HALF  = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       out_ready = 1'b0;
    wire        spi_miso;
    logic [7:0] out_data;
    logic       out_valid;
    logic       overrun;
    logic       frame_err;

    int         total = 0;
    int         bad = 0;
    int         fe_cycles = 0;
    int         pop_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_bytes[$];
    bit         model_ovr = 1'b0;

    spi_slave_rx #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] status_now();
        return {model_ovr, exp_q.size() == int'(DEPTH), exp_q.size() == 0, 5'b0};
    endfunction

    // Model of one completed byte: dropped only when the FIFO is full and nothing leaves
    task automatic model_push(input logic [7:0] b, input bit pop_same);
        if (exp_q.size() >= int'(DEPTH) && !pop_same) model_ovr = 1'b1;
        else exp_q.push_back(b);
    endtask

    // Monitor: every accepted output byte must match the model's oldest byte
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_cycles++;
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got %0h expected no data", out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input int n, input int half);
        for (int i = 7; i >= 8 - n; i--) begin
            spi_mosi = b[i];
            cycles(half);
            spi_sclk = 1'b1;
            cycles(half);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int half, input bit pop_same,
                             input bit chk_miso, input logic [7:0] exp_miso);
        logic [7:0] mb;
        mb = '0;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            cycles(half);
            mb[i] = spi_miso;
            spi_sclk = 1'b1;
            if (i == 0) begin
                model_push(b, pop_same);
                if (pop_same) begin
                    // ready high only on the clock edge where the byte is pushed
                    cycles(SYNC);
                    out_ready = 1'b1;
                    cycles(1);
                    out_ready = 1'b0;
                    cycles(half - SYNC - 1);
                end else begin
                    cycles(half);
                end
            end else begin
                cycles(half);
            end
            spi_sclk = 1'b0;
        end
        if (chk_miso) check("miso_status", 32'(mb), 32'(exp_miso));
    endtask

    task automatic frame(input int half, input bit pop_last, input bit chk_all);
        logic [7:0] st;
        st = status_now();
        model_ovr = 1'b0;
        spi_cs_n = 1'b0;
        cycles(SYNC + 6);
        for (int k = 0; k < tx_bytes.size(); k++) begin
            send_byte(tx_bytes[k], half, pop_last && (k == tx_bytes.size() - 1),
                      (k == 0) || chk_all, st);
            st = status_now();
        end
        cycles(half);
        spi_cs_n = 1'b1;
        cycles(12);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int fe0;
        int nb;
        cycles(4);
        reset = 1'b0;
        cycles(10);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);

        // Single byte, consumer always ready
        out_ready = 1'b1;
        pop_cnt = 0;
        tx_bytes.delete();
        tx_bytes.push_back(8'hA5);
        frame(HALF, 1'b0, 1'b0);
        check("single_pops", 32'(pop_cnt), 32'd1);
        check("single_valid_after", 32'(out_valid), 32'd0);

        // Burst of five into a depth-4 FIFO with the consumer stalled
        out_ready = 1'b0;
        tx_bytes.delete();
        for (int i = 1; i <= 5; i++) tx_bytes.push_back(8'(i));
        frame(HALF, 1'b0, 1'b1);
        check("burst_overrun", 32'(overrun), 32'(model_ovr));
        check("burst_valid", 32'(out_valid), 32'd1);
        check("burst_head", 32'(out_data), 32'h01);

        // Next frame reads 8'hC0; its byte lands on a full FIFO together with a pop
        tx_bytes.delete();
        tx_bytes.push_back(8'hAA);
        frame(HALF, 1'b1, 1'b0);
        check("pushpop_overrun", 32'(overrun), 32'd0);
        pop_cnt = 0;
        out_ready = 1'b1;
        cycles(12);
        check("pushpop_drain_count", 32'(pop_cnt), 32'(DEPTH));
        check("pushpop_drained", 32'(out_valid), 32'd0);

        // Partial frame: five bits then cs_n rises
        fe0 = fe_cycles;
        model_ovr = 1'b0;
        spi_cs_n = 1'b0;
        cycles(SYNC + 6);
        send_bits(8'hFF, 5, HALF);
        cycles(HALF);
        spi_cs_n = 1'b1;
        cycles(12);
        check("partial_frame_err_cycles", 32'(fe_cycles - fe0), 32'd1);
        check("partial_fifo_empty", 32'(out_valid), 32'd0);
        tx_bytes.delete();
        tx_bytes.push_back(8'h3C);
        frame(HALF, 1'b0, 1'b0);

        // Reset in the middle of a byte with cs_n held low
        spi_cs_n = 1'b0;
        cycles(SYNC + 6);
        send_bits(8'hFF, 4, HALF);
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        exp_q.delete();
        model_ovr = 1'b0;
        fe0 = fe_cycles;
        send_bits(8'hF0, 4, HALF);
        cycles(HALF);
        check("lockout_no_push", 32'(out_valid), 32'd0);
        spi_cs_n = 1'b1;
        cycles(12);
        check("lockout_no_push_after_cs", 32'(out_valid), 32'd0);
        check("lockout_no_frame_err", 32'(fe_cycles - fe0), 32'd0);
        tx_bytes.delete();
        tx_bytes.push_back(8'h7E);
        frame(HALF, 1'b0, 1'b0);

        // Pointer wrap: ten bytes in one frame
        pop_cnt = 0;
        tx_bytes.delete();
        for (int i = 0; i < 10; i++) tx_bytes.push_back(8'(8'h10 + i));
        frame(HALF, 1'b0, 1'b0);
        check("wrap_pops", 32'(pop_cnt), 32'd10);
        check("wrap_overrun", 32'(overrun), 32'd0);

        // Random frames with random byte values and SCLK phase lengths
        for (int f = 0; f < 4; f++) begin
            tx_bytes.delete();
            nb = int'($urandom_range(1, 4));
            for (int k = 0; k < nb; k++) tx_bytes.push_back(8'($urandom));
            frame(int'($urandom_range(4, 8)), 1'b0, 1'b0);
        end
        check("random_overrun", 32'(overrun), 32'd0);

        cycles(10);
        check("final_model_drained", 32'(exp_q.size()), 32'd0);
        check("final_valid", 32'(out_valid), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
